// File: rtl/pif_regs.sv
// pif_regs: register file behind the PIF/I2C slave front end.
// ID bytes, scratch, LED, free-running counter with snapshot, 8-deep byte FIFO and status.
module pif_regs #(
  parameter int XA_W  = 6,
  parameter int XSA_W = 3,
  parameter int XD_W  = 6
) (
  input  logic             xclk,
  input  logic             sys_rst,
  input  logic             XI_PWr,
  input  logic [XA_W-1:0]  XI_PRWA,
  input  logic             XI_PRdFinished,
  input  logic [XSA_W-1:0] XI_PRdSubA,
  input  logic [XD_W-1:0]  XI_PD,
  output logic [7:0]       XO,
  output logic [XD_W-1:0]  led,
  output logic             fifo_nempty
);

  localparam logic [XA_W-1:0] A_ID      = XA_W'(0);
  localparam logic [XA_W-1:0] A_SCRATCH = XA_W'(1);
  localparam logic [XA_W-1:0] A_LED     = XA_W'(2);
  localparam logic [XA_W-1:0] A_COUNTER = XA_W'(3);
  localparam logic [XA_W-1:0] A_FIFO    = XA_W'(4);
  localparam logic [XA_W-1:0] A_STATUS  = XA_W'(5);

  logic [XA_W-1:0] prev_addr_q;
  logic            addr_chg;
  logic [7:0]      pd_ext;
  logic [1:0]      sub2;

  logic [1:0]      wsub_q, wsub_d;
  logic            scratch_we;
  logic [7:0]      scratch_q [4];

  logic [XD_W-1:0] led_q;
  logic            led_we;

  logic [15:0]     cnt_q;
  logic [15:0]     snap_q, snap_d;

  logic [7:0]      xo_q, xo_d;

  logic [7:0]      fifo_mem [8];
  logic [2:0]      wr_ptr_q, wr_ptr_d;
  logic [2:0]      rd_ptr_q, rd_ptr_d;
  logic [3:0]      count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            push, pop, push_ok, pop_ok;
  logic            fifo_full, fifo_empty, fifo_clr, stat_clr, mem_we;

  logic            unused_sub;
  assign unused_sub = ^XI_PRdSubA[XSA_W-1:2];

  assign addr_chg = (XI_PRWA != prev_addr_q);
  assign pd_ext   = 8'(XI_PD);
  assign sub2     = XI_PRdSubA[1:0];

  // Address tracking, used both for the write index reset and the counter snapshot
  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) prev_addr_q <= '0;
    else          prev_addr_q <= XI_PRWA;
  end

  assign scratch_we = XI_PWr && (XI_PRWA == A_SCRATCH);

  always_comb begin
    wsub_d = wsub_q;
    if (addr_chg)        wsub_d = 2'd0;
    else if (scratch_we) wsub_d = wsub_q + 2'd1;
  end

  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      wsub_q <= 2'd0;
      for (int i = 0; i < 4; i++) scratch_q[i] <= 8'h00;
    end else begin
      wsub_q <= wsub_d;
      if (scratch_we) scratch_q[wsub_q] <= pd_ext;
    end
  end

  assign led_we = XI_PWr && (XI_PRWA == A_LED);

  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst)    led_q <= '0;
    else if (led_we) led_q <= XI_PD;
  end

  // Snapshot on entry to the counter address and after the master has taken the high byte
  always_comb begin
    snap_d = snap_q;
    if (XI_PRWA == A_COUNTER) begin
      if (addr_chg || (XI_PRdFinished && XI_PRdSubA[0])) snap_d = cnt_q;
    end
  end

  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      cnt_q  <= 16'h0000;
      snap_q <= 16'h0000;
    end else begin
      cnt_q  <= cnt_q + 16'd1;
      snap_q <= snap_d;
    end
  end

  assign push       = XI_PWr && (XI_PRWA == A_FIFO);
  assign pop        = XI_PRdFinished && (XI_PRWA == A_FIFO);
  assign fifo_clr   = XI_PWr && (XI_PRWA == A_STATUS) && XI_PD[0];
  assign stat_clr   = XI_PRdFinished && (XI_PRWA == A_STATUS);
  assign fifo_full  = (count_q == 4'd8);
  assign fifo_empty = (count_q == 4'd0);
  assign pop_ok     = pop && !fifo_empty;
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts a paired push
  assign push_ok    = push && (!fifo_full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    mem_we   = 1'b0;
    if (stat_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (fifo_clr) begin
      wr_ptr_d = 3'd0;
      rd_ptr_d = 3'd0;
      count_d  = 4'd0;
    end else begin
      if (push_ok) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 3'd1;
      end
      if (push && !push_ok) ovf_d = 1'b1;
      if (pop_ok)           rd_ptr_d = rd_ptr_q + 3'd1;
      if (pop && !pop_ok)   udf_d = 1'b1;
      if (push_ok && !pop_ok)      count_d = count_q + 4'd1;
      else if (pop_ok && !push_ok) count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 4'd0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage needs no reset: occupancy lives in count_q and the pointers
  always_ff @(posedge xclk) begin
    if (mem_we) fifo_mem[wr_ptr_q] <= pd_ext;
  end

  always_comb begin
    xo_d = 8'h00;
    case (XI_PRWA)
      A_ID: begin
        case (sub2)
          2'd0:    xo_d = 8'h50;
          2'd1:    xo_d = 8'h49;
          2'd2:    xo_d = 8'h46;
          default: xo_d = 8'h01;
        endcase
      end
      A_SCRATCH: xo_d = scratch_q[sub2];
      A_LED:     xo_d = 8'(led_q);
      A_COUNTER: xo_d = XI_PRdSubA[0] ? snap_q[15:8] : snap_q[7:0];
      A_FIFO:    xo_d = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];
      A_STATUS:  xo_d = {ovf_q, udf_q, 2'b00, count_q};
      default:   xo_d = 8'h00;
    endcase
  end

  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) xo_q <= 8'h00;
    else          xo_q <= xo_d;
  end

  assign XO          = xo_q;
  assign led         = led_q;
  assign fifo_nempty = !fifo_empty;

endmodule

// File: doc/pif_regs.md
PIF_REGS -- requirements
Module: pif_regs

Interface
REQ-001 The parameter XA_W SHALL default to 6 and SHALL set the width of XI_PRWA, matching pifdefs.v `TXA+1.
REQ-002 The parameter XSA_W SHALL default to 3 and SHALL set the width of XI_PRdSubA, matching pifdefs.v `TXSubA+1.
REQ-003 The parameter XD_W SHALL default to 6 and SHALL set the width of XI_PD and led, matching pifdefs.v `I2C_DATA_BITS.
REQ-004 The block SHALL use a single clock, xclk; reset SHALL be asynchronous and active-low on sys_rst. Port list:
- xclk  in  1  clock
- sys_rst  in  1  async active-low reset
- XI_PWr  in  1  single-cycle write strobe
- XI_PRWA  in  XA_W  current register address
- XI_PRdFinished  in  1  single-cycle strobe, byte read by I2C master
- XI_PRdSubA  in  XSA_W  read sub-address
- XI_PD  in  XD_W  write data
- XO  out  8  read data to the I2C front end
- led  out  XD_W  LED register
- fifo_nempty  out  1  FIFO holds at least 1 entry

Function
REQ-005 Register map by XI_PRWA: 0 = ID, 1 = SCRATCH, 2 = LED, 3 = COUNTER, 4 = FIFO, 5 = STATUS; all other addresses SHALL read 0x00 and SHALL ignore writes.
REQ-006 XO SHALL be registered: XO at cycle n+1 = f(XI_PRWA, XI_PRdSubA, state) at cycle n.
REQ-007 ID SHALL return constant bytes 0x50, 0x49, 0x46, 0x01 for PRdSubA[1:0] = 0, 1, 2, 3; writes to ID SHALL be ignored.
REQ-008 The block SHALL keep a 2-bit write index wsub, cleared in any cycle where XI_PRWA differs from its value in the previous cycle, otherwise incremented mod 4 on each XI_PWr to address 1.
REQ-009 SCRATCH: XI_PWr SHALL store XI_PD (zero-extended to 8 bits) into scratch[wsub]; a read SHALL return scratch[PRdSubA[1:0]].
REQ-010 LED: XI_PWr SHALL load led <= XI_PD; a read SHALL return led zero-extended.
REQ-011 COUNTER: the 16-bit counter cnt SHALL increment every cycle and wrap from 0xFFFF to 0x0000.
REQ-012 The register snap SHALL load cnt in the cycle after XI_PRWA changes to 3, and on XI_PRdFinished with address 3 and PRdSubA[0] = 1; reads SHALL return snap[7:0] for PRdSubA[0] = 0 and snap[15:8] for PRdSubA[0] = 1.
REQ-013 FIFO: the FIFO SHALL be 8 entries deep and 8 bits wide. XI_PWr to address 4 SHALL push XI_PD zero-extended. XI_PRdFinished at address 4 SHALL pop. XO SHALL show the head entry, or 0x00 when empty. The sub-address SHALL be ignored.
REQ-014 A push when full SHALL be dropped and SHALL set sticky ovf. A pop when empty SHALL be ignored and SHALL set sticky udf.
REQ-015 A simultaneous push and pop when non-empty SHALL leave count unchanged, including when full, with no ovf. When empty, the push SHALL be stored, the pop ignored, and udf set.
REQ-016 STATUS read SHALL return {ovf, udf, 2'b00, count[3:0]}, with count from 0 to 8. XI_PRdFinished at address 5 SHALL clear ovf and udf. XI_PWr at address 5 with XI_PD[0] = 1 SHALL empty the FIFO; it SHALL leave the flags unchanged.
REQ-017 fifo_nempty SHALL equal (count != 0) and SHALL be registered or derived directly from registered state.

Reset
REQ-018 While sys_rst = 0 the block SHALL hold: XO = 0x00, led = 0, fifo_nempty = 0, cnt = 0, snap = 0, scratch = 0, wsub = 0, FIFO empty, ovf = udf = 0, previous-address register = 0.
REQ-019 Reset asserted mid-operation SHALL discard FIFO contents and flags immediately, without waiting for a clock edge; the first clock after release SHALL count as a normal cycle.

Verification
REQ-020 The bench SHALL cover: reset release, PRWA = 0, PRdSubA stepping 0 to 3 -> XO = 0x50, 0x49, 0x46, 0x01, each one cycle after the sub-address changes.
REQ-021 The bench SHALL cover: PRWA = 1, five PWr with PD = 0x11, 0x12, 0x13, 0x14, 0x15 -> scratch = {0x15, 0x12, 0x13, 0x14}. PRWA then set to 2 and back to 1, one PWr with 0x2A -> scratch[0] = 0x2A.
REQ-022 The bench SHALL cover: PRWA set to 3 while cnt = 0x12FF, then the read of sub 0 and sub 1 -> XO = 0xFF then 0x12 while cnt keeps running; after PRdFinished at sub 1, snap is reloaded.
REQ-023 The bench SHALL cover: PRWA = 4, nine pushes 0x01 to 0x09 -> count 8 and ovf = 1. Nine pops then return 0x01 to 0x08, fifo_nempty goes to 0 after the eighth pop, and the ninth pop sets udf. A STATUS read then returns 0xC0, and the following STATUS read returns 0x00.
REQ-024 The bench SHALL cover: FIFO full, with PWr and PRdFinished asserted in the same cycle at address 4 -> count stays 8, ovf = 0, and the head advances.
REQ-025 The bench SHALL cover: three pushes, then sys_rst pulsed low for half a cycle -> fifo_nempty = 0, XO = 0x00, led = 0 immediately.
